// File: rtl/inv_shiftsub_unit.sv
// Iterative InvShiftRows + InvSubBytes stage for the AES-128 decrypt path.
// The shifted state is substituted SBOX_COUNT bytes per cycle.
module inv_shiftsub_unit #(
    parameter int SBOX_COUNT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int GROUPS = 16 / SBOX_COUNT;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

    generate
        if (SBOX_COUNT != 1 && SBOX_COUNT != 2 && SBOX_COUNT != 4 &&
            SBOX_COUNT != 8 && SBOX_COUNT != 16) begin : g_bad_param
            $error("inv_shiftsub_unit: SBOX_COUNT must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Inverse S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    // out[r][c] = in[r][(c-r) mod 4]; byte i sits at row i%4, column i/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (4 * c + row) -: 8] =
                    s[127 - 8 * (4 * ((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [127:0]       shift_reg;
    logic [127:0]       result_reg;
    logic [127:0]       result_next;
    logic               in_ready_reg;
    logic               out_valid_reg;

    logic [3:0]         lane     [SBOX_COUNT];
    logic [7:0]         sub_byte [SBOX_COUNT];

    generate
        for (genvar gi = 0; gi < SBOX_COUNT; gi++) begin : g_sbox
            assign lane[gi]     = 4'(int'(cnt_reg) * SBOX_COUNT + gi);
            assign sub_byte[gi] = inv_sbox(shift_reg[127 - 8 * int'(lane[gi]) -: 8]);
        end
    endgenerate

    always_comb begin
        result_next = result_reg;
        for (int i = 0; i < SBOX_COUNT; i++) begin
            result_next[127 - 8 * int'(lane[i]) -: 8] = sub_byte[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            result_reg    <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg    <= inv_shift_rows(in_data);
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= BUSY;
                    end
                end
                BUSY: begin
                    result_reg <= result_next;
                    if (cnt_reg == LAST_CNT) begin
                        cnt_reg       <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Result register is left untouched so out_data holds after the handshake.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = result_reg;

endmodule

// File: tb/tb_inv_shiftsub_unit.sv
// Self-checking bench for inv_shiftsub_unit: vector table, scoreboard, corner sequences
// and latency of every legal SBOX_COUNT.
module tb_inv_shiftsub_unit;

    localparam int P   = 4;
    localparam int LAT = 16 / P + 1;

    localparam logic [127:0] C1_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] ALL52  = {16{8'h52}};
    localparam logic [127:0] ALL63  = {16{8'h63}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    logic         m_in_valid;
    logic [127:0] m_in_data;
    logic         m_out_ready;
    logic         m_in_ready  [4];
    logic         m_out_valid [4];
    logic [127:0] m_out_data  [4];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    inv_shiftsub_unit #(.SBOX_COUNT(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_multi
            localparam int MP = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
            inv_shiftsub_unit #(.SBOX_COUNT(MP)) u_multi (
                .clk(clk), .rst_n(rst_n),
                .in_valid(m_in_valid), .in_ready(m_in_ready[gi]), .in_data(m_in_data),
                .out_valid(m_out_valid[gi]), .out_ready(m_out_ready), .out_data(m_out_data[gi])
            );
        end
    endgenerate

    // ---------------- reference model (S-box derived from GF(2^8) arithmetic) ----------------
    logic [7:0] m_inv [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        if (x != 8'h00) begin
            r = 8'h01;
            for (int i = 0; i < 254; i++) r = gmul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] o;
        int src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            src = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
            o[127 - 8 * i -: 8] = m_inv[d[127 - 8 * src -: 8]];
        end
        return o;
    endfunction

    function automatic void check(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [127:0] exp_q[$];
    logic [127:0] cur_exp;
    int           acc_cyc = 0;
    int           hs_cyc  = -1;
    bit           lat_pending = 0;
    bit           prev_ov = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_ov     = 0;
            lat_pending = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                acc_cyc     = cyc;
                lat_pending = 1;
                $display("accept  cyc=%0d in_data=%h", cyc, in_data);
            end
            if (out_valid && !prev_ov) begin
                checks++;
                if (!lat_pending || (cyc - acc_cyc) != LAT) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles required %0d", cyc - acc_cyc, LAT);
                end
                lat_pending = 0;
            end
            if (out_valid && out_ready) begin
                checks++;
                hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_result: got %h required no output", out_data);
                end else begin
                    logic [127:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL out_data: got %h required %h", out_data, e);
                    end else begin
                        $display("result  cyc=%0d out_data=%h", cyc, out_data);
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0 required 1");
        end
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] e);
        @(posedge clk); #1;
        in_data  = d;
        cur_exp  = e;
        in_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
    endtask

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs [3];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int a, a2, n;
        bit ok;
        bit         seen  [4];
        int         lat_m [4];
        logic [127:0] dat_m [4];

        for (int x = 0; x < 256; x++) m_inv[fwd_sbox(8'(x))] = 8'(x);
        vecs[0] = '{din: '0,     dout: ALL52};
        vecs[1] = '{din: ALL63,  dout: '0};
        vecs[2] = '{din: C1_IN,  dout: C1_OUT};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cur_exp = '0;
        m_in_valid = 1'b0; m_in_data = '0; m_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out_data", out_data, '0);

        // Table-driven vectors
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].din, vecs[i].dout);
            wait_drain();
        end

        // Random blocks checked against the reference model
        for (int i = 0; i < 4; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(d, model(d));
        end
        wait_drain();

        // Backpressure with in_data/in_valid wiggling while the unit is full
        out_ready = 1'b0;
        send(C1_IN, C1_OUT);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = ALL63;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ok = out_valid && !in_ready && (out_data === C1_OUT);
            check("backpressure_hold", {out_valid, in_ready, out_data}, {1'b1, 1'b0, C1_OUT});
            $display("stall   cyc=%0d ok=%0d", cyc, ok);
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("hold_after_handshake", {out_valid, out_data}, {1'b0, C1_OUT});

        // Back-to-back with in_valid held high
        @(posedge clk); #1;
        in_data = C1_IN; cur_exp = C1_OUT; in_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        in_data = '0; cur_exp = ALL52;
        wait_accept();
        a2 = cyc;
        check("b2b_accept_cycle", 128'(a2), 128'(hs_cyc + 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);
        check("b2b_no_duplicate", 128'(out_valid), 128'(0));

        // Reset in the middle of BUSY
        send(C1_IN, C1_OUT);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midreset_state", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 128'h0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) ok = 0;
        end
        check("midreset_no_result", 128'(ok), 128'(1));
        send(vecs[1].din, vecs[1].dout);
        wait_drain();

        // Latency of every other SBOX_COUNT, all instances started on the same edge
        m_out_ready = 1'b1;
        @(posedge clk); #1;
        m_in_data  = C1_IN;
        m_in_valid = 1'b1;
        @(negedge clk);
        check("multi_ready", {m_in_ready[0], m_in_ready[1], m_in_ready[2], m_in_ready[3]}, 128'hf);
        a = cyc;
        @(posedge clk); #1;
        m_in_valid = 1'b0;
        m_in_data  = '0;
        for (int i = 0; i < 4; i++) begin seen[i] = 0; lat_m[i] = -1; dat_m[i] = '0; end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!seen[i] && m_out_valid[i]) begin
                    seen[i]  = 1;
                    lat_m[i] = cyc - a;
                    dat_m[i] = m_out_data[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            int pv;
            pv = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 8 : 16;
            $display("multi   P=%0d latency=%0d out_data=%h", pv, lat_m[i], dat_m[i]);
            check($sformatf("multi_latency_P%0d", pv), 128'(lat_m[i]), 128'(16 / pv + 1));
            check($sformatf("multi_data_P%0d", pv), dat_m[i], C1_OUT);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
